// File: rtl/tetris_event_bridge_pkg.sv
// Shared constants and the line-clear scoring table for the game-event bridge.
package tetris_event_bridge_pkg;

  localparam int unsigned NUM_PIECES      = 7;
  localparam int unsigned FROMGAME_SCORE  = 0;
  localparam int unsigned FROMGAME_ROTATE = 1;
  localparam int unsigned LFSR_W          = 16;
  localparam logic [2:0]  POINTS_MAX      = 3'd7;

  // Points awarded for a drop that clears the given number of rows; 4 or more pays the max.
  function automatic logic [2:0] points_lut(input logic [2:0] lines);
    case (lines)
      3'd0:    points_lut = 3'd0;
      3'd1:    points_lut = 3'd1;
      3'd2:    points_lut = 3'd3;
      3'd3:    points_lut = 3'd5;
      default: points_lut = 3'd7;
    endcase
  endfunction

endpackage

// File: rtl/tetris_event_bridge_if.sv
// Game-side event inputs and regfile-side event outputs of the bridge.
interface tetris_event_bridge_if;

  logic       btn_rotate_raw;
  logic       lines_valid;
  logic [2:0] lines_cleared;
  logic       piece_req;
  logic       cpu_write_busy;
  logic [2:0] addPoints;
  logic       rotate;
  logic [1:0] fromGame;
  logic [3:0] blockType;
  logic       piece_valid;

  // Game/regfile side: drives raw events, consumes the bridged outputs.
  modport master (
    output btn_rotate_raw, lines_valid, lines_cleared, piece_req, cpu_write_busy,
    input  addPoints, rotate, fromGame, blockType, piece_valid
  );

  // Bridge side.
  modport slave (
    input  btn_rotate_raw, lines_valid, lines_cleared, piece_req, cpu_write_busy,
    output addPoints, rotate, fromGame, blockType, piece_valid
  );

endinterface

// File: rtl/tetris_event_bridge_btn_debounce.sv
// Two-flop synchroniser followed by a stability counter for the rotate button.
module btn_debounce #(
  parameter int unsigned DEBOUNCE_CYCLES = 250000
) (
  input  logic clock,
  input  logic ctrl_reset,
  input  logic btn_raw_i,
  output logic level_o,
  output logic rise_pulse_o
);

  localparam int unsigned CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

  logic [1:0]    sync_q;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          level_q, level_d;
  logic          btn_sync, differ, expire;

  assign btn_sync = sync_q[1];

  // Bring the asynchronous button into the clock domain.
  always_ff @(posedge clock) begin
    // NOTE: non-blocking assignments here so every flop samples pre-edge values, whatever the statement order.
    if (ctrl_reset) sync_q <= '0;
    else            sync_q <= {sync_q[0], btn_raw_i};
  end

  // Count consecutive cycles of disagreement; flip the level once it has lasted long enough.
  always_comb begin
    // NOTE: defaults first so every path assigns every output and no latch is inferred.
    cnt_d   = '0;
    level_d = level_q;
    differ  = (btn_sync != level_q);
    expire  = differ && (cnt_q == CNT_MAX);
    if (expire) begin
      level_d = ~level_q;
    end else if (differ) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // Debounce state register.
  always_ff @(posedge clock) begin
    if (ctrl_reset) begin
      cnt_q   <= '0;
      level_q <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      level_q <= level_d;
    end
  end

  assign level_o      = level_q;
  // High in the cycle whose closing edge turns the level from 0 to 1.
  assign rise_pulse_o = expire && !level_q;

endmodule

// File: rtl/tetris_event_bridge.sv
// Bridges game events (rotate button, line clears, piece requests) into the regfile's
// game-input side, holding score/rotate events until a cycle with no CPU write.
module tetris_event_bridge
  import tetris_event_bridge_pkg::*;
#(
  parameter int unsigned       DEBOUNCE_CYCLES = 250000,
  parameter logic [LFSR_W-1:0] LFSR_SEED       = 16'hACE1
) (
  input logic                  clock,
  input logic                  ctrl_reset,
  tetris_event_bridge_if.slave bus
);

  logic              rot_rise, rot_level;
  logic [2:0]        add_points_q, add_points_d;
  logic [1:0]        from_game_q, from_game_d;
  logic [3:0]        block_type_q, block_type_d;
  logic              piece_valid_q, piece_valid_d;
  logic              req_pending_q, req_pending_d;
  logic [LFSR_W-1:0] lfsr_q;
  logic              score_accept, rotate_accept, piece_take;
  logic [2:0]        score_base;
  logic [3:0]        score_sum;

  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_btn_debounce (
    .clock        (clock),
    .ctrl_reset   (ctrl_reset),
    .btn_raw_i    (bus.btn_rotate_raw),
    .level_o      (rot_level),
    .rise_pulse_o (rot_rise)
  );

  // Free-running Fibonacci LFSR (taps 16,14,13,11); a non-zero seed keeps it off the all-zero lockup.
  always_ff @(posedge clock) begin
    if (ctrl_reset) lfsr_q <= LFSR_SEED;
    else            lfsr_q <= {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
  end

  // Score and rotate event hold: a pending event is consumed by the first non-busy cycle,
  // and a new event arriving in that same cycle starts fresh instead of accumulating.
  always_comb begin
    from_game_d   = from_game_q;
    add_points_d  = add_points_q;
    score_accept  = from_game_q[FROMGAME_SCORE]  && !bus.cpu_write_busy;
    rotate_accept = from_game_q[FROMGAME_ROTATE] && !bus.cpu_write_busy;
    score_base    = score_accept ? 3'd0 : add_points_q;
    score_sum     = {1'b0, score_base} + {1'b0, points_lut(bus.lines_cleared)};

    if (bus.lines_valid && (bus.lines_cleared != 3'd0)) begin
      add_points_d                = (score_sum > 4'(POINTS_MAX)) ? POINTS_MAX : score_sum[2:0];
      from_game_d[FROMGAME_SCORE] = 1'b1;
    end else if (score_accept) begin
      add_points_d                = 3'd0;
      from_game_d[FROMGAME_SCORE] = 1'b0;
    end

    if (rot_rise)           from_game_d[FROMGAME_ROTATE] = 1'b1;
    else if (rotate_accept) from_game_d[FROMGAME_ROTATE] = 1'b0;
  end

  // Piece request: sample the LFSR each pending cycle, retrying while the draw is out of range.
  always_comb begin
    block_type_d  = block_type_q;
    piece_valid_d = 1'b0;
    piece_take    = req_pending_q && (int'(lfsr_q[2:0]) < NUM_PIECES);
    if (piece_take) begin
      block_type_d  = {1'b0, lfsr_q[2:0]};
      piece_valid_d = 1'b1;
    end
    req_pending_d = (req_pending_q && !piece_take) || bus.piece_req;
  end

  // Output and event registers.
  always_ff @(posedge clock) begin
    if (ctrl_reset) begin
      add_points_q  <= '0;
      from_game_q   <= '0;
      block_type_q  <= '0;
      piece_valid_q <= 1'b0;
      req_pending_q <= 1'b0;
    end else begin
      add_points_q  <= add_points_d;
      from_game_q   <= from_game_d;
      block_type_q  <= block_type_d;
      piece_valid_q <= piece_valid_d;
      req_pending_q <= req_pending_d;
    end
  end

  assign bus.addPoints   = add_points_q;
  assign bus.fromGame    = from_game_q;
  assign bus.rotate      = from_game_q[FROMGAME_ROTATE];
  assign bus.blockType   = block_type_q;
  assign bus.piece_valid = piece_valid_q;

  // The debounced level itself is not forwarded; only its rising edge produces an event.
  logic unused_level;
  assign unused_level = rot_level;

endmodule

// File: tb/tb_tetris_event_bridge.sv
// Directed + randomized bench for tetris_event_bridge (debounce shortened to 4 cycles).
module tb_tetris_event_bridge;

  localparam int unsigned DEB  = 4;
  localparam logic [15:0] SEED = 16'hACE1;

  logic clock = 1'b0;
  logic ctrl_reset;
  int   checks = 0;
  int   errors = 0;

  tetris_event_bridge_if bus();

  tetris_event_bridge #(.DEBOUNCE_CYCLES(DEB), .LFSR_SEED(SEED)) dut (
    .clock      (clock),
    .ctrl_reset (ctrl_reset),
    .bus        (bus)
  );

  always #5 clock = ~clock;

  // Reference LFSR: the sequence of states the piece generator walks through since reset.
  logic [15:0] m_lfsr;
  always @(posedge clock) begin
    if (ctrl_reset) m_lfsr <= SEED;
    else            m_lfsr <= {m_lfsr[14:0], ^(m_lfsr & 16'hB400)};
  end

  int lut [8] = '{0, 1, 3, 5, 7, 7, 7, 7};

  task automatic check(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    @(negedge clock);
  endtask

  int m_pts, m_fg0, cur, seen, found;
  bit lv, busy;
  int lc;

  initial begin
    ctrl_reset = 1'b1;
    bus.btn_rotate_raw = 0; bus.lines_valid = 0; bus.lines_cleared = 0;
    bus.piece_req = 0; bus.cpu_write_busy = 0;

    // 1. Reset
    tick(); tick();
    check("reset_fromGame", bus.fromGame, 0);
    check("reset_addPoints", bus.addPoints, 0);
    check("reset_blockType", bus.blockType, 0);
    check("reset_piece_valid", bus.piece_valid, 0);
    ctrl_reset = 1'b0;
    tick();

    // 2a. Short glitch must not produce a rotate event
    bus.btn_rotate_raw = 1; tick(); tick();
    bus.btn_rotate_raw = 0;
    seen = 0;
    for (int i = 0; i < 12; i++) begin tick(); seen += int'(bus.fromGame[1]); end
    check("glitch_no_rotate", seen, 0);

    // 2b. Long press: event appears exactly at the 6th edge after the rise, then clears
    bus.btn_rotate_raw = 1;
    seen = 0;
    for (int k = 0; k < 10; k++) begin
      tick();
      check($sformatf("press_fg1_e%0d", k), bus.fromGame[1], (k == 5) ? 1 : 0);
      check($sformatf("press_rot_e%0d", k), bus.rotate, (k == 5) ? 1 : 0);
      seen += int'(bus.rotate);
    end
    check("press_once", seen, 1);
    bus.btn_rotate_raw = 0;
    seen = 0;
    for (int i = 0; i < 12; i++) begin tick(); seen += int'(bus.fromGame[1]); end
    check("release_no_rotate", seen, 0);

    // 3. Score held while busy, consumed on first non-busy cycle
    bus.cpu_write_busy = 1;
    bus.lines_valid = 1; bus.lines_cleared = 3'd2; tick();
    bus.lines_valid = 0;
    for (int i = 0; i < 3; i++) begin
      check($sformatf("busy_hold_fg0_%0d", i), bus.fromGame[0], 1);
      check($sformatf("busy_hold_pts_%0d", i), bus.addPoints, 3);
      if (i < 2) tick();
    end
    bus.cpu_write_busy = 0;
    check("nonbusy_still_held", bus.fromGame[0], 1);
    tick();
    check("cleared_fg0", bus.fromGame[0], 0);
    check("cleared_pts", bus.addPoints, 0);

    // 4. Accumulation and saturation while busy
    bus.cpu_write_busy = 1;
    bus.lines_valid = 1;
    bus.lines_cleared = 3'd3; tick(); check("acc_3", bus.addPoints, 5);
    bus.lines_cleared = 3'd4; tick(); check("acc_4_sat", bus.addPoints, 7);
    bus.lines_cleared = 3'd1; tick(); check("acc_1_sat", bus.addPoints, 7);
    bus.lines_cleared = 3'd0; tick(); check("zero_lines_noop", bus.addPoints, 7);
    // New event in the accepting cycle starts fresh
    bus.cpu_write_busy = 0;
    bus.lines_cleared = 3'd1; tick();
    check("fresh_pts", bus.addPoints, 1);
    check("fresh_fg0", bus.fromGame[0], 1);
    bus.lines_valid = 0; tick();
    check("fresh_cleared", bus.fromGame[0], 0);

    // Randomized score traffic against the rule-level model
    m_pts = 0; m_fg0 = 0;
    for (int i = 0; i < 300; i++) begin
      busy = ($urandom_range(0, 2) != 0);
      lv   = ($urandom_range(0, 2) == 0);
      lc   = $urandom_range(0, 7);
      bus.cpu_write_busy = busy; bus.lines_valid = lv; bus.lines_cleared = 3'(lc);
      if (m_fg0 == 1 && !busy) begin m_fg0 = 0; m_pts = 0; end
      if (lv && lc != 0) begin
        m_pts = (m_pts + lut[lc] > 7) ? 7 : m_pts + lut[lc];
        m_fg0 = 1;
      end
      tick();
      check($sformatf("rand_pts_%0d", i), bus.addPoints, m_pts);
      check($sformatf("rand_fg0_%0d", i), bus.fromGame[0], m_fg0);
    end
    bus.lines_valid = 0; bus.cpu_write_busy = 0; tick();

    // 5. 100 piece requests compared against the reference LFSR, including retries on 7
    for (int r = 0; r < 100; r++) begin
      bus.cpu_write_busy = 1'($urandom_range(0, 1));
      bus.piece_req = 1; tick();
      bus.piece_req = 0;
      check($sformatf("req_no_same_cycle_%0d", r), bus.piece_valid, 0);
      found = 0;
      for (int w = 0; w < 40 && found == 0; w++) begin
        cur = int'(m_lfsr) % 8;
        tick();
        if (cur != 7) begin
          found = 1;
          check($sformatf("piece_valid_%0d", r), bus.piece_valid, 1);
          check($sformatf("piece_type_%0d", r), bus.blockType, cur);
        end else begin
          check($sformatf("piece_retry_%0d", r), bus.piece_valid, 0);
        end
      end
      check($sformatf("piece_found_%0d", r), found, 1);
      check($sformatf("piece_range_%0d", r), int'(bus.blockType < 7), 1);
      tick();
      check($sformatf("piece_pulse_%0d", r), bus.piece_valid, 0);
      for (int g = $urandom_range(0, 3); g > 0; g--) tick();
    end

    // 6. Reset with both events pending and a piece request outstanding
    bus.cpu_write_busy = 1;
    bus.btn_rotate_raw = 1;
    found = 0;
    for (int w = 0; w < 20 && found == 0; w++) begin tick(); found = int'(bus.fromGame[1]); end
    check("rotate_wait", found, 1);
    bus.lines_valid = 1; bus.lines_cleared = 3'd2; bus.piece_req = 1; tick();
    bus.lines_valid = 0; bus.piece_req = 0;
    check("pre_reset_fromGame", bus.fromGame, 3);
    ctrl_reset = 1; bus.btn_rotate_raw = 0; tick();
    check("midreset_fromGame", bus.fromGame, 0);
    check("midreset_addPoints", bus.addPoints, 0);
    check("midreset_blockType", bus.blockType, 0);
    check("midreset_piece_valid", bus.piece_valid, 0);
    ctrl_reset = 0;
    seen = 0;
    for (int i = 0; i < 12; i++) begin
      tick();
      seen += int'(bus.piece_valid) + int'(bus.fromGame != 2'b00);
    end
    check("post_reset_quiet", seen, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
